// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch front end.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_t;

  localparam int DEPTH_DEF  = 4;
  localparam int ADDR_W_DEF = 8;

  // Instruction byte layout seen by the decoder.
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int OPR_MSB = 3;
  localparam int OPR_LSB = 0;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {instruction, pc} pairs. The flush input overrides push and pop,
// and the head outputs read as zero while the buffer is empty.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [7:0]             push_inst,
  input  logic [ADDR_W-1:0]      push_pc,
  output logic [7:0]             head_inst,
  output logic [ADDR_W-1:0]      head_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]        mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_inst[wr_ptr] <= push_inst;
      mem_pc[wr_ptr]   <= push_pc;
    end
  end

  assign head_inst = (count != '0) ? mem_inst[rd_ptr] : '0;
  assign head_pc   = (count != '0) ? mem_pc[rd_ptr]   : '0;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding memory request, prefetch buffer, redirect flush.
//   state   | meaning
//   S_FETCH | issue a request at fetch_pc when the buffer has room
//   S_WAIT  | request outstanding, address held until imem_ack
//   S_DROP  | redirected while outstanding; hold old address, discard its ack
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  output logic [7:0]        inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state, state_nx;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nx;
  logic [ADDR_W-1:0] req_addr, req_addr_nx;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              has_room;

  // Only one request is ever in flight and FETCH never has one pending, so room is just count.
  assign has_room   = count < CNT_W'(DEPTH);
  assign inst_valid = count != '0;
  assign pop        = inst_valid && inst_ready && !redirect;

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    req_addr_nx = req_addr;
    push        = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = req_addr;
    case (state)
      S_FETCH: begin
        imem_addr = fetch_pc;
        imem_req  = has_room && !reset;
        if (imem_req) begin
          req_addr_nx = fetch_pc;
          if (imem_ack) begin
            push = !redirect;
            if (!redirect) fetch_pc_nx = fetch_pc + ADDR_W'(1);
          end else begin
            state_nx = redirect ? S_DROP : S_WAIT;
          end
        end
        if (redirect) fetch_pc_nx = redirect_pc;
      end
      S_WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          push     = !redirect;
          state_nx = S_FETCH;
          if (!redirect) fetch_pc_nx = fetch_pc + ADDR_W'(1);
        end else if (redirect) begin
          state_nx = S_DROP;
        end
        if (redirect) fetch_pc_nx = redirect_pc;
      end
      S_DROP: begin
        imem_req = 1'b1;
        if (imem_ack) state_nx = S_FETCH;
        if (redirect) fetch_pc_nx = redirect_pc;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      fetch_pc <= '0;
      req_addr <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      req_addr <= req_addr_nx;
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_inst (imem_rdata),
    .push_pc   (fetch_pc),
    .head_inst (inst),
    .head_pc   (inst_pc),
    .count     (count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized traffic, checked against a
// stream model (accepted pcs run consecutively from the last redirect, data = pc + 0x10).
module tb_inst_fetch;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [7:0]    imem_rdata = '0;
  logic [7:0]    inst;
  logic [AW-1:0] inst_pc;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;

  always #5 clk = ~clk;

  inst_fetch #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  int         n_assert = 0;
  int         n_fail = 0;
  int         lat = 0;
  int         waited = 0;
  int         beats = 0;
  bit         force_ack = 0;
  bit         redir_on_ack = 0;
  bit         redir_done = 0;
  logic [7:0] redir_on_ack_pc = '0;
  logic [7:0] exp_pc = '0;
  bit         prev_pend = 0;
  logic [7:0] prev_addr = '0;
  logic [7:0] accepted[$];
  logic [7:0] wrap_exp[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  function automatic logic [7:0] mem_f(input logic [7:0] a);
    return a + 8'h10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory with programmable ack latency; lat=0 acks in the request cycle.
  task automatic mem_drive();
    if (force_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 8'hEE;
    end else if (imem_req) begin
      if (waited >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_f(imem_addr);
        waited     = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 8'($urandom);
        waited++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 8'($urandom);
      waited     = 0;
    end
  endtask

  // One clock: drive memory, check protocol and stream, advance to 1ns past the edge.
  task automatic cycle();
    bit fired;
    bit was_redir;
    fired = 0;
    mem_drive();
    if (redir_on_ack && imem_ack && imem_req) begin
      redirect     = 1'b1;
      redirect_pc  = redir_on_ack_pc;
      redir_on_ack = 0;
      redir_done   = 1;
      fired        = 1;
    end
    if (prev_pend) begin
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", 32'(imem_addr), 32'(prev_addr));
    end
    prev_pend = imem_req && !imem_ack;
    prev_addr = imem_addr;
    if (imem_req && imem_ack) beats++;
    was_redir = redirect;
    if (redirect) begin
      exp_pc = redirect_pc;
    end else if (inst_valid && inst_ready) begin
      chk("stream_pc", 32'(inst_pc), 32'(exp_pc));
      chk("stream_inst", 32'(inst), 32'(mem_f(exp_pc)));
      accepted.push_back(inst_pc);
      exp_pc++;
    end
    @(posedge clk);
    #1;
    if (was_redir) chk("flush_valid", 32'(inst_valid), 32'd0);
    if (fired) redirect = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"}, 32'(inst), 32'd0);
    chk({tag, "_pc"}, 32'(inst_pc), 32'd0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    imem_ack  = 1'b0;
    redirect  = 1'b0;
    force_ack = 0;
    waited    = 0;
    prev_pend = 0;
    exp_pc    = '0;
    beats     = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1);
  end

  initial begin
    // Zero-wait stream after reset.
    do_reset();
    lat = 0;
    inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("zw_valid", 32'(inst_valid), 32'd1);
      chk("zw_inst", 32'(inst), 32'(8'h10 + 8'(k)));
      chk("zw_pc", 32'(inst_pc), 32'(k));
    end

    // Buffer fills to DEPTH with decoder stalled, stray ack ignored, then drains gap-free.
    do_reset();
    inst_ready = 1'b0;
    repeat (8) cycle();
    chk("fill_beats", 32'(beats), 32'(DEPTH));
    chk("fill_req", 32'(imem_req), 32'd0);
    chk("fill_head", 32'(inst_pc), 32'd0);
    force_ack = 1;
    cycle();
    force_ack = 0;
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("no_gap", 32'(inst_valid), 32'd1);
      cycle();
    end
    chk("resume_valid", 32'(inst_valid), 32'd1);
    chk("resume_pc", 32'(inst_pc), 32'd4);

    // Redirect while waiting on a 2-cycle memory.
    do_reset();
    lat = 2;
    inst_ready = 1'b1;
    cycle();
    redirect = 1'b1;
    redirect_pc = 8'h40;
    cycle();
    redirect = 1'b0;
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr", 32'(imem_addr), 32'd0);
    cycle();
    chk("after_drop_req", 32'(imem_req), 32'd1);
    chk("after_drop_addr", 32'(imem_addr), 32'h40);
    chk("after_drop_valid", 32'(inst_valid), 32'd0);
    for (int k = 0; k < 20 && !inst_valid; k++) cycle();
    chk("drop_first_valid", 32'(inst_valid), 32'd1);
    chk("drop_first_pc", 32'(inst_pc), 32'h40);
    chk("drop_first_inst", 32'(inst), 32'h50);

    // Redirect coincident with an ack.
    redir_on_ack = 1;
    redir_on_ack_pc = 8'h80;
    redir_done = 0;
    for (int k = 0; k < 20 && !redir_done; k++) cycle();
    chk("ack_redir_fired", 32'(redir_done), 32'd1);
    chk("ack_redir_addr", 32'(imem_addr), 32'h80);
    chk("ack_redir_req", 32'(imem_req), 32'd1);
    for (int k = 0; k < 20 && !inst_valid; k++) cycle();
    chk("ack_redir_pc", 32'(inst_pc), 32'h80);

    // Address wrap.
    lat = 0;
    redirect = 1'b1;
    redirect_pc = 8'hFE;
    cycle();
    redirect = 1'b0;
    accepted.delete();
    repeat (8) cycle();
    chk("wrap_count", 32'(accepted.size() >= 4), 32'd1);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] got;
      got = (k < accepted.size()) ? accepted[k] : 8'hxx;
      chk("wrap_pc", 32'(got), 32'(wrap_exp[k]));
    end

    // Asynchronous reset while waiting with two entries buffered.
    do_reset();
    lat = 2;
    inst_ready = 1'b0;
    for (int k = 0; k < 30 && beats < 2; k++) cycle();
    cycle();
    chk("mid_setup_valid", 32'(inst_valid), 32'd1);
    chk("mid_setup_req", 32'(imem_req), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    do_reset();
    lat = 0;
    inst_ready = 1'b1;
    cycle();
    chk("restart_valid", 32'(inst_valid), 32'd1);
    chk("restart_pc", 32'(inst_pc), 32'd0);

    // Randomized traffic.
    do_reset();
    accepted.delete();
    lat = $urandom_range(0, 3);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(0, 3);
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect = 1'b1;
        redirect_pc = 8'($urandom);
      end
      if (!redir_on_ack && $urandom_range(0, 39) == 0) begin
        redir_on_ack = 1;
        redir_on_ack_pc = 8'($urandom);
      end
      cycle();
      redirect = 1'b0;
    end
    chk("progress", 32'(accepted.size() > 500), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
